fpu_dispatch_initiator: RTL and testbench

CPU-side initiator for the CPU↔FPU coprocessor protocol. It takes one microcode request at a time: an ESC instruction (with an optional memory operand load or store, or an FLDCW control-word write) or an FWAIT. It sequences the handshakes the FPU expects (instruction/ack, data write, data read/ready, wait/ready), applies busy synchronization and a timeout, and returns one response to the CPU core. It sits between the CPU microcode sequencer and the FPU8087 top level.

---
 rtl/fpu_proto_pkg.sv | 36 +++
 rtl/fpu_dispatch_timer.sv | 30 +++
 rtl/fpu_dispatch_initiator.sv | 173 +++++++++++++++++
 tb/tb_fpu_dispatch_initiator.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_proto_pkg.sv
// Shared CPU<->FPU protocol definitions: request kinds, initiator states,
// operand size codes and a small state classification helper.
package fpu_proto_pkg;

   typedef enum logic [1:0] {
      KIND_ESC   = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2,
      KIND_WAIT  = 2'd3
   } req_kind_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      ISSUE = 3'd2,
      LOAD  = 3'd3,
      CTRL  = 3'd4,
      READ  = 3'd5,
      WAITF = 3'd6,
      RESP  = 3'd7
   } state_t;

   // Operand size codes, passed through to the FPU untouched
   localparam logic [2:0] DSIZE_I16 = 3'd0;
   localparam logic [2:0] DSIZE_I32 = 3'd1;
   localparam logic [2:0] DSIZE_I64 = 3'd2;
   localparam logic [2:0] DSIZE_F32 = 3'd3;
   localparam logic [2:0] DSIZE_F64 = 3'd4;
   localparam logic [2:0] DSIZE_F80 = 3'd5;

   // States that wait on the FPU and are therefore guarded by the timeout
   function automatic logic is_timed(input state_t s);
      return (s == SYNC) || (s == ISSUE) || (s == READ) || (s == WAITF);
   endfunction

endpackage

// File: rtl/fpu_dispatch_timer.sv
// Timeout down-counter: clear restarts the countdown, enable decrements,
// expired flags the last permitted cycle of a wait.
module fpu_dispatch_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int            CW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] START = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Reload on clear, otherwise count down and stick at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= START;
      end else if (clear) begin
         count <= START;
      end else if (enable && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/fpu_dispatch_initiator.sv
// CPU-side initiator for the FPU coprocessor handshake. Accepts one
// microcode request, walks the FPU handshakes and returns one response.
// Every output is a register loaded from the next state, so strobes
// drop on the same edge that samples their handshake.
module fpu_dispatch_initiator
   import fpu_proto_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic [7:0]  req_opcode,
   input  logic [7:0]  req_modrm,
   input  logic [2:0]  req_data_size,
   input  logic [79:0] req_data,
   input  logic        req_ctrl_write,
   input  logic [15:0] req_ctrl_word,
   output logic        rsp_valid,
   output logic [79:0] rsp_data,
   output logic [15:0] rsp_status,
   output logic        rsp_exception,
   output logic        rsp_timeout,
   output logic        fpu_instr_valid,
   output logic [7:0]  fpu_opcode,
   output logic [7:0]  fpu_modrm,
   input  logic        fpu_instr_ack,
   output logic        fpu_data_write,
   output logic        fpu_data_read,
   output logic [2:0]  fpu_data_size,
   output logic [79:0] fpu_data_wr,
   input  logic [79:0] fpu_data_rd,
   input  logic        fpu_data_ready,
   input  logic        fpu_busy,
   input  logic        fpu_exception,
   input  logic        fpu_ready,
   input  logic [15:0] fpu_status_word,
   output logic [15:0] fpu_control_word,
   output logic        fpu_ctrl_write,
   output logic        fpu_wait
);
   state_t    state, next_state;
   req_kind_t kind_q;
   logic      ctrl_q;
   logic      accept;
   logic      timeout_hit;
   logic      timer_clear;
   logic      timer_enable;
   logic      timer_expired;

   assign accept       = (state == IDLE) && req_valid;
   assign timer_clear  = is_timed(next_state) && (next_state != state);
   assign timer_enable = is_timed(state);

   fpu_dispatch_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state decode; a handshake seen on the expiry cycle still wins
   always_comb begin
      next_state  = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE:  if (accept) next_state = (req_kind == KIND_WAIT) ? WAITF : SYNC;
         SYNC: begin
            if (!fpu_busy) begin
               next_state = ISSUE;
            end else if (timer_expired) begin
               next_state  = RESP;
               timeout_hit = 1'b1;
            end
         end
         ISSUE: begin
            if (fpu_instr_ack) begin
               case (kind_q)
                  KIND_LOAD:  next_state = LOAD;
                  KIND_STORE: next_state = READ;
                  default:    next_state = ctrl_q ? CTRL : RESP;
               endcase
            end else if (timer_expired) begin
               next_state  = RESP;
               timeout_hit = 1'b1;
            end
         end
         LOAD:  next_state = RESP;
         CTRL:  next_state = RESP;
         READ: begin
            if (fpu_data_ready) begin
               next_state = RESP;
            end else if (timer_expired) begin
               next_state  = RESP;
               timeout_hit = 1'b1;
            end
         end
         WAITF: begin
            if (fpu_ready && !fpu_busy) begin
               next_state = RESP;
            end else if (timer_expired) begin
               next_state  = RESP;
               timeout_hit = 1'b1;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Registered outputs, request latches and response capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_ready        <= 1'b1;
         rsp_valid        <= 1'b0;
         rsp_data         <= '0;
         rsp_status       <= '0;
         rsp_exception    <= 1'b0;
         rsp_timeout      <= 1'b0;
         fpu_instr_valid  <= 1'b0;
         fpu_opcode       <= '0;
         fpu_modrm        <= '0;
         fpu_data_write   <= 1'b0;
         fpu_data_read    <= 1'b0;
         fpu_data_size    <= '0;
         fpu_data_wr      <= '0;
         fpu_control_word <= '0;
         fpu_ctrl_write   <= 1'b0;
         fpu_wait         <= 1'b0;
         kind_q           <= KIND_ESC;
         ctrl_q           <= 1'b0;
      end else begin
         req_ready       <= (next_state == IDLE);
         fpu_instr_valid <= (next_state == ISSUE);
         fpu_data_write  <= (next_state == LOAD);
         fpu_ctrl_write  <= (next_state == CTRL);
         fpu_data_read   <= (next_state == READ);
         fpu_wait        <= (next_state == WAITF);
         rsp_valid       <= (next_state == RESP);
         if (accept) begin
            kind_q           <= req_kind_t'(req_kind);
            ctrl_q           <= req_ctrl_write && (req_kind == KIND_ESC);
            fpu_opcode       <= req_opcode;
            fpu_modrm        <= req_modrm;
            fpu_data_size    <= req_data_size;
            fpu_data_wr      <= req_data;
            fpu_control_word <= req_ctrl_word;
            rsp_data         <= '0;
            rsp_status       <= '0;
            rsp_exception    <= 1'b0;
            rsp_timeout      <= 1'b0;
         end
         if ((state == READ) && fpu_data_ready) rsp_data <= fpu_data_rd;
         if (next_state == RESP) begin
            rsp_status    <= fpu_status_word;
            rsp_exception <= fpu_exception;
            rsp_timeout   <= timeout_hit;
         end
      end
   end

endmodule

// File: tb/tb_fpu_dispatch_initiator.sv
// Bench for fpu_dispatch_initiator: a default-timeout instance for the
// handshake scenarios and a short-timeout instance for the abort path.
module tb_fpu_dispatch_initiator;
   import fpu_proto_pkg::*;

   localparam int TO_B = 16;

   typedef struct packed {
      logic [79:0] data;
      logic [15:0] status;
      logic        exc;
      logic        timeout;
   } exp_t;

   logic clk, reset_n;
   logic req_valid, req_valid_b;
   logic [1:0]  req_kind;
   logic [7:0]  req_opcode, req_modrm;
   logic [2:0]  req_data_size;
   logic [79:0] req_data;
   logic        req_ctrl_write;
   logic [15:0] req_ctrl_word;
   logic        fpu_instr_ack, fpu_data_ready, fpu_busy, fpu_exception, fpu_ready;
   logic [79:0] fpu_data_rd;
   logic [15:0] fpu_status_word;

   logic        req_ready, rsp_valid, rsp_exception, rsp_timeout;
   logic        fpu_instr_valid, fpu_data_write, fpu_data_read, fpu_ctrl_write, fpu_wait;
   logic [79:0] rsp_data, fpu_data_wr;
   logic [15:0] rsp_status, fpu_control_word;
   logic [7:0]  fpu_opcode, fpu_modrm;
   logic [2:0]  fpu_data_size;

   logic        req_ready_b, rsp_valid_b, rsp_exception_b, rsp_timeout_b;
   logic        fpu_instr_valid_b, fpu_data_write_b, fpu_data_read_b, fpu_ctrl_write_b, fpu_wait_b;
   logic [79:0] rsp_data_b, fpu_data_wr_b;
   logic [15:0] rsp_status_b, fpu_control_word_b;
   logic [7:0]  fpu_opcode_b, fpu_modrm_b;
   logic [2:0]  fpu_data_size_b;

   logic [218:0] outs_a;
   assign outs_a = {rsp_valid, rsp_data, rsp_status, rsp_exception, rsp_timeout,
                    fpu_instr_valid, fpu_opcode, fpu_modrm, fpu_data_write, fpu_data_read,
                    fpu_data_size, fpu_data_wr, fpu_control_word, fpu_ctrl_write, fpu_wait};

   int   checks = 0;
   int   errors = 0;
   int   rsp_cnt = 0;
   int   rsp_cnt_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   fpu_dispatch_initiator dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_opcode(req_opcode), .req_modrm(req_modrm),
      .req_data_size(req_data_size), .req_data(req_data), .req_ctrl_write(req_ctrl_write),
      .req_ctrl_word(req_ctrl_word), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .rsp_exception(rsp_exception), .rsp_timeout(rsp_timeout),
      .fpu_instr_valid(fpu_instr_valid), .fpu_opcode(fpu_opcode), .fpu_modrm(fpu_modrm),
      .fpu_instr_ack(fpu_instr_ack), .fpu_data_write(fpu_data_write), .fpu_data_read(fpu_data_read),
      .fpu_data_size(fpu_data_size), .fpu_data_wr(fpu_data_wr), .fpu_data_rd(fpu_data_rd),
      .fpu_data_ready(fpu_data_ready), .fpu_busy(fpu_busy), .fpu_exception(fpu_exception),
      .fpu_ready(fpu_ready), .fpu_status_word(fpu_status_word), .fpu_control_word(fpu_control_word),
      .fpu_ctrl_write(fpu_ctrl_write), .fpu_wait(fpu_wait)
   );

   fpu_dispatch_initiator #(.TIMEOUT_CYCLES(TO_B)) dut_to (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_kind(req_kind), .req_opcode(req_opcode), .req_modrm(req_modrm),
      .req_data_size(req_data_size), .req_data(req_data), .req_ctrl_write(req_ctrl_write),
      .req_ctrl_word(req_ctrl_word), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
      .rsp_status(rsp_status_b), .rsp_exception(rsp_exception_b), .rsp_timeout(rsp_timeout_b),
      .fpu_instr_valid(fpu_instr_valid_b), .fpu_opcode(fpu_opcode_b), .fpu_modrm(fpu_modrm_b),
      .fpu_instr_ack(fpu_instr_ack), .fpu_data_write(fpu_data_write_b), .fpu_data_read(fpu_data_read_b),
      .fpu_data_size(fpu_data_size_b), .fpu_data_wr(fpu_data_wr_b), .fpu_data_rd(fpu_data_rd),
      .fpu_data_ready(fpu_data_ready), .fpu_busy(fpu_busy), .fpu_exception(fpu_exception),
      .fpu_ready(fpu_ready), .fpu_status_word(fpu_status_word), .fpu_control_word(fpu_control_word_b),
      .fpu_ctrl_write(fpu_ctrl_write_b), .fpu_wait(fpu_wait_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Scoreboard: every response pulse is matched against the oldest expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rsp_valid === 1'b1) begin
         rsp_cnt++;
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got data=%h timeout=%b, none expected", rsp_data, rsp_timeout);
         end else begin
            e = q_a.pop_front();
            if ({rsp_data, rsp_status, rsp_exception, rsp_timeout} !== e) begin
               errors++;
               $display("FAIL rsp: got %h/%h/%b/%b expected %h/%h/%b/%b", rsp_data, rsp_status,
                        rsp_exception, rsp_timeout, e.data, e.status, e.exc, e.timeout);
            end
         end
      end
      if (rsp_valid_b === 1'b1) begin
         rsp_cnt_b++;
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL rsp_b_unexpected: got timeout=%b, none expected", rsp_timeout_b);
         end else begin
            e = q_b.pop_front();
            if ({rsp_data_b, rsp_status_b, rsp_exception_b, rsp_timeout_b} !== e) begin
               errors++;
               $display("FAIL rsp_b: got %h/%h/%b/%b expected %h/%h/%b/%b", rsp_data_b, rsp_status_b,
                        rsp_exception_b, rsp_timeout_b, e.data, e.status, e.exc, e.timeout);
            end
         end
      end
   end

   // Present a request at a falling edge; returns at the falling edge after acceptance
   task automatic send_req(input logic sel_b, input logic [1:0] kind, input logic [7:0] op,
                           input logic [7:0] modrm, input logic [79:0] data,
                           input logic cw, input logic [15:0] cword);
      req_kind       = kind;
      req_opcode     = op;
      req_modrm      = modrm;
      req_data_size  = DSIZE_F80;
      req_data       = data;
      req_ctrl_write = cw;
      req_ctrl_word  = cword;
      if (sel_b) req_valid_b = 1'b1;
      else       req_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid   = 1'b0;
      req_valid_b = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
      end
      checks++;
      if (outs_a !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", outs_a);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || outs_a !== '0 || req_ready_b !== 1'b1) begin
         errors++; $display("FAIL idle_after_reset: ready=%b ready_b=%b outs=%h", req_ready, req_ready_b, outs_a);
      end
   endtask

   task automatic test_esc();
      int n0;
      n0 = rsp_cnt;
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      send_req(1'b0, KIND_ESC, 8'hD9, 8'hE8, 80'h0, 1'b0, 16'h0);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++; $display("FAIL esc_ready_drop: got %b expected 0", req_ready);
      end
      for (int i = 0; i < 20 && fpu_instr_valid !== 1'b1; i++) @(negedge clk);
      checks++;
      if (fpu_instr_valid !== 1'b1 || fpu_opcode !== 8'hD9 || fpu_modrm !== 8'hE8) begin
         errors++; $display("FAIL esc_issue: valid=%b op=%h modrm=%h expected 1 d9 e8",
                            fpu_instr_valid, fpu_opcode, fpu_modrm);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (fpu_instr_valid !== 1'b1) begin
         errors++; $display("FAIL esc_valid_held: got %b expected 1", fpu_instr_valid);
      end
      fpu_instr_ack = 1'b1;
      @(negedge clk);
      fpu_instr_ack = 1'b0;
      checks++;
      if (fpu_instr_valid !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL esc_ack: valid=%b rsp_valid=%b expected 0 1", fpu_instr_valid, rsp_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_cnt - n0 !== 1) begin
         errors++; $display("FAIL esc_rsp_count: got %0d expected 1", rsp_cnt - n0);
      end
   endtask

   task automatic test_load();
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      // ctrl flag on a load must be ignored
      send_req(1'b0, KIND_LOAD, 8'hDB, 8'h2E, 80'h3FFF8000000000000000, 1'b1, 16'h1234);
      for (int i = 0; i < 20 && fpu_instr_valid !== 1'b1; i++) @(negedge clk);
      fpu_instr_ack = 1'b1;
      @(negedge clk);
      fpu_instr_ack = 1'b0;
      checks++;
      if (fpu_data_write !== 1'b1 || fpu_data_wr !== 80'h3FFF8000000000000000 ||
          fpu_data_size !== DSIZE_F80 || fpu_ctrl_write !== 1'b0) begin
         errors++; $display("FAIL load_write: wr=%b data=%h size=%0d cw=%b expected 1 3fff8000000000000000 5 0",
                            fpu_data_write, fpu_data_wr, fpu_data_size, fpu_ctrl_write);
      end
      @(negedge clk);
      checks++;
      if (fpu_data_write !== 1'b0 || rsp_valid !== 1'b1 || fpu_ctrl_write !== 1'b0) begin
         errors++; $display("FAIL load_done: wr=%b rsp_valid=%b cw=%b expected 0 1 0",
                            fpu_data_write, rsp_valid, fpu_ctrl_write);
      end
   endtask

   task automatic test_store();
      fpu_status_word = 16'h4100;
      fpu_exception   = 1'b1;
      q_a.push_back({80'h4000C000000000000000, 16'h4100, 1'b1, 1'b0});
      send_req(1'b0, KIND_STORE, 8'hDB, 8'h3E, 80'h0, 1'b0, 16'h0);
      for (int i = 0; i < 20 && fpu_instr_valid !== 1'b1; i++) @(negedge clk);
      fpu_instr_ack = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         fpu_instr_ack = 1'b0;
         checks++;
         if (fpu_data_read !== 1'b1) begin
            errors++; $display("FAIL store_read_held: cycle %0d got %b expected 1", i, fpu_data_read);
         end
         if (i == 5) begin
            fpu_data_ready = 1'b1;
            fpu_data_rd    = 80'h4000C000000000000000;
         end
      end
      @(negedge clk);
      fpu_data_ready = 1'b0;
      fpu_data_rd    = 80'h0;
      checks++;
      if (fpu_data_read !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL store_done: read=%b rsp_valid=%b expected 0 1", fpu_data_read, rsp_valid);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (rsp_data !== 80'h4000C000000000000000) begin
         errors++; $display("FAIL store_hold: got %h expected 4000c000000000000000", rsp_data);
      end
      fpu_status_word = 16'h3800;
      fpu_exception   = 1'b0;
   endtask

   task automatic test_busy();
      fpu_busy = 1'b1;
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      send_req(1'b0, KIND_ESC, 8'hDE, 8'hC1, 80'h0, 1'b0, 16'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (fpu_instr_valid !== 1'b0) begin
            errors++; $display("FAIL busy_hold: cycle %0d valid=%b expected 0", i, fpu_instr_valid);
         end
      end
      fpu_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (fpu_instr_valid !== 1'b1) begin
         errors++; $display("FAIL busy_release: valid=%b expected 1", fpu_instr_valid);
      end
      fpu_instr_ack = 1'b1;
      @(negedge clk);
      fpu_instr_ack = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL busy_rsp: rsp_valid=%b expected 1", rsp_valid);
      end
   endtask

   task automatic test_fwait();
      fpu_ready = 1'b0;
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      send_req(1'b0, KIND_WAIT, 8'h9B, 8'h00, 80'h0, 1'b0, 16'h0);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (fpu_wait !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL fwait_hold: cycle %0d wait=%b rsp_valid=%b expected 1 0", i, fpu_wait, rsp_valid);
         end
         @(negedge clk);
      end
      fpu_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (fpu_wait !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL fwait_done: wait=%b rsp_valid=%b expected 0 1", fpu_wait, rsp_valid);
      end
      @(negedge clk);
      // minimum-latency FWAIT: response on the second edge after acceptance
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      send_req(1'b0, KIND_WAIT, 8'h9B, 8'h00, 80'h0, 1'b0, 16'h0);
      checks++;
      if (fpu_wait !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL fwait_lat0: wait=%b rsp_valid=%b expected 1 0", fpu_wait, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL fwait_lat1: rsp_valid=%b expected 1", rsp_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_fldcw();
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      send_req(1'b0, KIND_ESC, 8'hD9, 8'h2E, 80'h0, 1'b1, 16'h037F);
      for (int i = 0; i < 20 && fpu_instr_valid !== 1'b1; i++) @(negedge clk);
      fpu_instr_ack = 1'b1;
      @(negedge clk);
      fpu_instr_ack = 1'b0;
      checks++;
      if (fpu_ctrl_write !== 1'b1 || fpu_control_word !== 16'h037F || fpu_instr_valid !== 1'b0) begin
         errors++; $display("FAIL fldcw_pulse: cw=%b word=%h valid=%b expected 1 037f 0",
                            fpu_ctrl_write, fpu_control_word, fpu_instr_valid);
      end
      @(negedge clk);
      checks++;
      if (fpu_ctrl_write !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL fldcw_done: cw=%b rsp_valid=%b expected 0 1", fpu_ctrl_write, rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = rsp_cnt;
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      q_a.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      req_kind       = KIND_WAIT;
      req_ctrl_write = 1'b0;
      req_valid      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_resp: rsp_valid=%b ready=%b expected 1 0", rsp_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_idle: ready=%b expected 1", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_cnt - n0 !== 2) begin
         errors++; $display("FAIL b2b_count: got %0d expected 2", rsp_cnt - n0);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      cnt = 0;
      q_b.push_back({80'h0, fpu_status_word, 1'b0, 1'b1});
      send_req(1'b1, KIND_ESC, 8'hD9, 8'hC9, 80'h0, 1'b0, 16'h0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fpu_instr_valid_b === 1'b1) cnt++;
         else if (cnt > 0) break;
      end
      checks++;
      if (cnt !== TO_B) begin
         errors++; $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TO_B);
      end
      checks++;
      if (fpu_instr_valid_b !== 1'b0 || rsp_valid_b !== 1'b1 || rsp_timeout_b !== 1'b1) begin
         errors++; $display("FAIL timeout_abort: valid=%b rsp_valid=%b timeout=%b expected 0 1 1",
                            fpu_instr_valid_b, rsp_valid_b, rsp_timeout_b);
      end
      @(negedge clk);
      checks++;
      if (req_ready_b !== 1'b1) begin
         errors++; $display("FAIL timeout_ready: got %b expected 1", req_ready_b);
      end
      q_b.push_back({80'h0, fpu_status_word, 1'b0, 1'b0});
      send_req(1'b1, KIND_WAIT, 8'h9B, 8'h00, 80'h0, 1'b0, 16'h0);
      @(negedge clk);
      checks++;
      if (rsp_valid_b !== 1'b1 || rsp_timeout_b !== 1'b0) begin
         errors++; $display("FAIL timeout_next: rsp_valid=%b timeout=%b expected 1 0", rsp_valid_b, rsp_timeout_b);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      n0 = rsp_cnt;
      send_req(1'b0, KIND_STORE, 8'hDD, 8'h1E, 80'h0, 1'b0, 16'h0);
      for (int i = 0; i < 20 && fpu_instr_valid !== 1'b1; i++) @(negedge clk);
      fpu_instr_ack = 1'b1;
      @(negedge clk);
      fpu_instr_ack = 1'b0;
      checks++;
      if (fpu_data_read !== 1'b1) begin
         errors++; $display("FAIL rst_mid_read: got %b expected 1", fpu_data_read);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || outs_a !== '0) begin
         errors++; $display("FAIL rst_mid_clear: ready=%b outs=%h expected 1 0", req_ready, outs_a);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_cnt !== n0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_norsp: rsp delta=%0d ready=%b expected 0 1", rsp_cnt - n0, req_ready);
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      req_valid       = 1'b0;
      req_valid_b     = 1'b0;
      req_kind        = 2'd0;
      req_opcode      = 8'h0;
      req_modrm       = 8'h0;
      req_data_size   = 3'd0;
      req_data        = 80'h0;
      req_ctrl_write  = 1'b0;
      req_ctrl_word   = 16'h0;
      fpu_instr_ack   = 1'b0;
      fpu_data_ready  = 1'b0;
      fpu_data_rd     = 80'h0;
      fpu_busy        = 1'b0;
      fpu_exception   = 1'b0;
      fpu_ready       = 1'b1;
      fpu_status_word = 16'h3800;

      test_reset();
      test_esc();
      @(negedge clk);
      test_load();
      @(negedge clk);
      test_store();
      test_busy();
      @(negedge clk);
      test_fwait();
      test_fldcw();
      @(negedge clk);
      test_back_to_back();
      test_timeout();
      @(negedge clk);
      test_reset_mid();

      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++; $display("FAIL pending_rsp: %0d/%0d responses never arrived, expected 0/0", q_a.size(), q_b.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
